// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the sequential floating-point adder/subtractor.
//   state_e      : controller state encoding (also visible on Debug)
//   RM_*         : rounding-mode encodings for Rnd_mode
//   EXC_*        : bit positions inside the 4-bit Exc vector {NV, OF, UF, NX}
//   round_up()   : rounding increment decision from mode, sign and G/R/S
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int EXC_NV = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

  // Returns 1 when the truncated magnitude must be incremented by one ulp.
  // RNE: round up above half, or exactly half with an odd lsb (ties to even).
  function automatic logic round_up(input logic [1:0] rm, input logic sign,
                                    input logic lsb, input logic g,
                                    input logic r, input logic s);
    logic inc;
    case (rm)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RDN:  inc = sign & (g | r | s);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   din   : input vector, WIDTH bits
//   count : number of zeros above the most significant set bit (WIDTH if din is 0)
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the highest set bit is the last one to update the count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CNT_W'(WIDTH - 1 - i);
      else        count = count;
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754-style adder/subtractor, one operation in flight.
//   CLK, RSTn          : clock, asynchronous active-low reset
//   In_valid/In_ready  : operation handshake (ready only in IDLE)
//   Datain1, Datain2   : operands A and B; Sub selects A-B; Rnd_mode selects rounding
//   Dataout/_valid     : result, held with Exc until Out_ready is sampled high
//   Exc                : {NV, OF, UF, NX}
//   Debug              : current controller state
// Pipeline of states: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> OUT. The result is
// moved into the output registers on the first OUT cycle, so Dataout_valid rises
// five edges after the accepting edge.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   In_valid,
  output logic                   In_ready,
  input  logic [EXP_W+MAN_W:0]   Datain1,
  input  logic [EXP_W+MAN_W:0]   Datain2,
  input  logic                   Sub,
  input  logic [1:0]             Rnd_mode,
  output logic [EXP_W+MAN_W:0]   Dataout,
  output logic                   Dataout_valid,
  input  logic                   Out_ready,
  output logic [3:0]             Exc,
  output logic [2:0]             Debug
);
  import fp_pkg::*;

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int DW = MAN_W + 4;            // hidden + fraction + G + R + S
  localparam int EW = EXP_W + 2;            // exponent with headroom for carries
  localparam int SW = $clog2(DW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EW-1:0]    EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]    EXP_MAX   = {2'b00, EXP_ONES};
  localparam logic [EW-1:0]    SHIFT_LIM = EW'(DW - 1);
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  state_e state_r, state_s;
  logic   accept_s, in_ready_r;

  // Captured operation
  logic [W-1:0] a_r, b_r;
  logic [1:0]   rm_r;
  // Datapath registers
  logic          sign_r, eff_sub_r, special_r, zero_r;
  logic [EW-1:0] exp_r;
  logic [DW-1:0] sig1_r, sig2_r, mant_r;
  logic [DW:0]   sum_r;
  logic [W-1:0]  spec_res_r, res_r;
  logic [3:0]    spec_exc_r, res_exc_r;
  // Output registers
  logic [W-1:0]  dout_r;
  logic [3:0]    dexc_r;
  logic          dvalid_r;

  // ALIGN combinational signals
  logic [EXP_W-1:0] a_exp_s, b_exp_s, op1_exp_s, op2_exp_s;
  logic [MAN_W-1:0] a_frac_s, b_frac_s, op1_frac_s, op2_frac_s;
  logic             a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_snan_s, b_snan_s;
  logic             swap_s, op1_sign_s, special_s;
  logic [EW-1:0]    e1_s, e2_s, diff_s;
  logic [DW-1:0]    sig1_s, sig2_full_s, sig2_s;
  logic [2*DW-1:0]  ext_s;
  logic [W-1:0]     spec_res_s;
  logic [3:0]       spec_exc_s;
  // NORM combinational signals
  logic [SW-1:0]    lz_s;
  logic [EW-1:0]    lim_s, shamt_s, norm_exp_s;
  logic [DW-1:0]    norm_mant_s;
  logic             norm_zero_s;
  // ROUND combinational signals
  logic             inc_s, inexact_s, hid_s, inf_sel_s;
  logic [MAN_W+1:0] rsum_s;
  logic [MAN_W-1:0] frac_s;
  logic [EW-1:0]    rexp_s;
  logic [W-1:0]     round_res_s;
  logic [3:0]       round_exc_s;

  assign accept_s      = In_valid && in_ready_r;
  assign In_ready      = in_ready_r;
  assign Dataout       = dout_r;
  assign Dataout_valid = dvalid_r;
  assign Exc           = dexc_r;
  assign Debug         = state_r;

  fp_lzc #(.WIDTH(DW)) u_lzc (
    .din   (sum_r[DW-1:0]),
    .count (lz_s)
  );

  // Next-state logic: only IDLE and OUT wait on a handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_s = ST_ALIGN; else state_s = ST_IDLE;
      ST_ALIGN: state_s = ST_ADD;
      ST_ADD:   state_s = ST_NORM;
      ST_NORM:  state_s = ST_ROUND;
      ST_ROUND: state_s = ST_OUT;
      ST_OUT:   if (dvalid_r && Out_ready) state_s = ST_IDLE; else state_s = ST_OUT;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Operand classification, magnitude ordering and alignment shift.
  always_comb begin
    a_exp_s  = a_r[W-2:MAN_W];
    b_exp_s  = b_r[W-2:MAN_W];
    a_frac_s = a_r[MAN_W-1:0];
    b_frac_s = b_r[MAN_W-1:0];
    a_nan_s  = (a_exp_s == EXP_ONES) && (a_frac_s != {MAN_W{1'b0}});
    b_nan_s  = (b_exp_s == EXP_ONES) && (b_frac_s != {MAN_W{1'b0}});
    a_inf_s  = (a_exp_s == EXP_ONES) && (a_frac_s == {MAN_W{1'b0}});
    b_inf_s  = (b_exp_s == EXP_ONES) && (b_frac_s == {MAN_W{1'b0}});
    a_snan_s = a_nan_s && !a_frac_s[MAN_W-1];
    b_snan_s = b_nan_s && !b_frac_s[MAN_W-1];
    // Exponent:fraction compares as an unsigned magnitude, subnormals included.
    swap_s   = (b_r[W-2:0] > a_r[W-2:0]);
    if (swap_s) begin
      op1_sign_s = b_r[W-1];
      op1_exp_s  = b_exp_s;  op1_frac_s = b_frac_s;
      op2_exp_s  = a_exp_s;  op2_frac_s = a_frac_s;
    end else begin
      op1_sign_s = a_r[W-1];
      op1_exp_s  = a_exp_s;  op1_frac_s = a_frac_s;
      op2_exp_s  = b_exp_s;  op2_frac_s = b_frac_s;
    end
    // Subnormals: hidden bit 0, effective exponent 1.
    e1_s        = (op1_exp_s == {EXP_W{1'b0}}) ? EXP_ONE : {2'b00, op1_exp_s};
    e2_s        = (op2_exp_s == {EXP_W{1'b0}}) ? EXP_ONE : {2'b00, op2_exp_s};
    sig1_s      = {(op1_exp_s != {EXP_W{1'b0}}), op1_frac_s, 3'b000};
    sig2_full_s = {(op2_exp_s != {EXP_W{1'b0}}), op2_frac_s, 3'b000};
    diff_s      = e1_s - e2_s;
    // Upper half is the shifted significand, lower half collects shifted-out bits.
    ext_s       = {sig2_full_s, {DW{1'b0}}} >> diff_s;
    if (diff_s >= SHIFT_LIM) begin
      sig2_s = {{(DW-1){1'b0}}, |sig2_full_s};
    end else begin
      sig2_s = {ext_s[2*DW-1:DW+1], ext_s[DW] | (|ext_s[DW-1:0])};
    end
    special_s  = 1'b1;
    spec_res_s = {W{1'b0}};
    spec_exc_s = 4'b0000;
    if (a_nan_s || b_nan_s) begin
      spec_res_s         = QNAN;
      spec_exc_s[EXC_NV] = a_snan_s | b_snan_s;
    end else if (a_inf_s && b_inf_s) begin
      if (a_r[W-1] != b_r[W-1]) begin
        spec_res_s         = QNAN;
        spec_exc_s[EXC_NV] = 1'b1;
      end else begin
        spec_res_s = a_r;
      end
    end else if (a_inf_s) begin
      spec_res_s = a_r;
    end else if (b_inf_s) begin
      spec_res_s = b_r;
    end else begin
      special_s = 1'b0;
    end
  end

  // Normalisation: right shift on carry-out, else left shift clamped at exponent 1.
  always_comb begin
    lim_s       = exp_r - EXP_ONE;
    shamt_s     = ({{(EW-SW){1'b0}}, lz_s} > lim_s) ? lim_s : {{(EW-SW){1'b0}}, lz_s};
    norm_zero_s = (sum_r == {(DW+1){1'b0}});
    if (sum_r[DW]) begin
      norm_mant_s = {sum_r[DW:2], sum_r[1] | sum_r[0]};
      norm_exp_s  = exp_r + EXP_ONE;
    end else begin
      norm_mant_s = sum_r[DW-1:0] << shamt_s;
      norm_exp_s  = exp_r - shamt_s;
    end
  end

  // Rounding, overflow saturation, zero sign and final packing.
  always_comb begin
    inc_s     = round_up(rm_r, sign_r, mant_r[3], mant_r[2], mant_r[1], mant_r[0]);
    inexact_s = |mant_r[2:0];
    rsum_s    = {1'b0, mant_r[DW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    if (rsum_s[MAN_W+1]) begin
      hid_s  = 1'b1;
      frac_s = rsum_s[MAN_W:1];
      rexp_s = exp_r + EXP_ONE;
    end else begin
      hid_s  = rsum_s[MAN_W];
      frac_s = rsum_s[MAN_W-1:0];
      rexp_s = exp_r;
    end
    inf_sel_s   = (rm_r == RM_RNE) || ((rm_r == RM_RUP) && !sign_r) ||
                  ((rm_r == RM_RDN) && sign_r);
    round_res_s = {W{1'b0}};
    round_exc_s = 4'b0000;
    if (special_r) begin
      round_res_s = spec_res_r;
      round_exc_s = spec_exc_r;
    end else if (zero_r) begin
      // Exact cancellation gives +0 (-0 under RDN); like-signed zeros keep their sign.
      round_res_s = {(eff_sub_r ? (rm_r == RM_RDN) : sign_r), {(W-1){1'b0}}};
    end else if (rexp_s >= EXP_MAX) begin
      round_exc_s[EXC_OF] = 1'b1;
      round_exc_s[EXC_NX] = 1'b1;
      if (inf_sel_s) round_res_s = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      else           round_res_s = {sign_r, EXP_ONES[EXP_W-1:1], 1'b0, {MAN_W{1'b1}}};
    end else begin
      round_res_s         = {sign_r, (hid_s ? rexp_s[EXP_W-1:0] : {EXP_W{1'b0}}), frac_s};
      round_exc_s[EXC_NX] = inexact_s;
      round_exc_s[EXC_UF] = inexact_s & ~hid_s;
    end
  end

  // Controller state, ready flag and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
      dout_r     <= {W{1'b0}};
      dexc_r     <= 4'b0000;
      dvalid_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == ST_IDLE);
      if (state_r == ST_OUT && !dvalid_r) begin
        dout_r   <= res_r;
        dexc_r   <= res_exc_r;
        dvalid_r <= 1'b1;
      end else if (state_r == ST_OUT && Out_ready) begin
        dout_r   <= {W{1'b0}};
        dexc_r   <= 4'b0000;
        dvalid_r <= 1'b0;
      end
    end
  end

  // Datapath registers, each stage written only in its own state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      rm_r       <= 2'b00;
      sign_r     <= 1'b0;
      eff_sub_r  <= 1'b0;
      special_r  <= 1'b0;
      zero_r     <= 1'b0;
      exp_r      <= {EW{1'b0}};
      sig1_r     <= {DW{1'b0}};
      sig2_r     <= {DW{1'b0}};
      mant_r     <= {DW{1'b0}};
      sum_r      <= {(DW+1){1'b0}};
      spec_res_r <= {W{1'b0}};
      spec_exc_r <= 4'b0000;
      res_r      <= {W{1'b0}};
      res_exc_r  <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r  <= Datain1;
            b_r  <= {Datain2[W-1] ^ Sub, Datain2[W-2:0]};
            rm_r <= Rnd_mode;
          end
        end
        ST_ALIGN: begin
          sign_r     <= op1_sign_s;
          eff_sub_r  <= a_r[W-1] ^ b_r[W-1];
          exp_r      <= e1_s;
          sig1_r     <= sig1_s;
          sig2_r     <= sig2_s;
          special_r  <= special_s;
          spec_res_r <= spec_res_s;
          spec_exc_r <= spec_exc_s;
        end
        ST_ADD: begin
          if (eff_sub_r) sum_r <= {1'b0, sig1_r} - {1'b0, sig2_r};
          else           sum_r <= {1'b0, sig1_r} + {1'b0, sig2_r};
        end
        ST_NORM: begin
          mant_r <= norm_mant_s;
          exp_r  <= norm_exp_s;
          zero_r <= norm_zero_s;
        end
        ST_ROUND: begin
          res_r     <= round_res_s;
          res_exc_r <= round_exc_s;
        end
        default: begin
          res_r <= res_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed self-checking bench for fp_addsub_seq (binary32).
// Expected results are hand-computed IEEE-754 single-precision values.
module tb_fp_addsub_seq;

  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [31:0] Datain1 = 32'd0;
  logic [31:0] Datain2 = 32'd0;
  logic        Sub = 1'b0;
  logic [1:0]  Rnd_mode = 2'b00;
  logic [31:0] Dataout;
  logic        Dataout_valid;
  logic        Out_ready = 1'b1;
  logic [3:0]  Exc;
  logic [2:0]  Debug;

  int err_cnt = 0;
  int chk_cnt = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .In_valid      (In_valid),
    .In_ready      (In_ready),
    .Datain1       (Datain1),
    .Datain2       (Datain2),
    .Sub           (Sub),
    .Rnd_mode      (Rnd_mode),
    .Dataout       (Dataout),
    .Dataout_valid (Dataout_valid),
    .Out_ready     (Out_ready),
    .Exc           (Exc),
    .Debug         (Debug)
  );

  // 100 MHz-style free-running clock.
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one operation (called mid-cycle with In_ready high), check latency,
  // result and flags, then the return to IDLE when Out_ready is high.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [1:0] rm,
                        input logic [31:0] exp_d, input logic [3:0] exp_x);
    int cyc;
    check_eq({tag, ".rdy"}, 32'(In_ready), 32'd1);
    Datain1 = a; Datain2 = b; Sub = sub; Rnd_mode = rm; In_valid = 1'b1;
    @(posedge CLK); #1;
    // Scramble inputs: they must be ignored while busy.
    In_valid = 1'b0; Datain1 = 32'hDEADBEEF; Datain2 = 32'h12345678;
    Sub = ~sub; Rnd_mode = ~rm;
    cyc = 0;
    while (!Dataout_valid && cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check_eq({tag, ".lat"}, 32'(cyc), 32'd5);
    check_eq({tag, ".data"}, Dataout, exp_d);
    check_eq({tag, ".exc"}, 32'(Exc), 32'(exp_x));
    if (Out_ready) begin
      @(posedge CLK); #1;
      check_eq({tag, ".idle"}, {29'd0, Dataout_valid, In_ready, |Exc}, 32'd2);
    end
  endtask

  initial begin
    int bad;
    int seen;
    #12;
    check_eq("rst.ready", 32'(In_ready), 32'd1);
    check_eq("rst.valid", 32'(Dataout_valid), 32'd0);
    check_eq("rst.data", Dataout, 32'd0);
    check_eq("rst.exc", 32'(Exc), 32'd0);
    check_eq("rst.debug", 32'(Debug), 32'd0);
    #2 RSTn = 1'b1;

    // First accept on the first edge after reset release.
    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, RNE, 32'h40000000, 4'h0);
    run_op("cancel_rne",   32'h3F800000, 32'h3F800000, 1'b1, RNE, 32'h00000000, 4'h0);
    run_op("cancel_rdn",   32'h3F800000, 32'h3F800000, 1'b1, RDN, 32'h80000000, 4'h0);
    run_op("ovf_rne",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 32'h7F800000, 4'h5);
    run_op("ovf_rtz",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RTZ, 32'h7F7FFFFF, 4'h5);
    run_op("ovf_neg_rup",  32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RUP, 32'hFF7FFFFF, 4'h5);
    run_op("tie_rne",      32'h3F800000, 32'h33800000, 1'b0, RNE, 32'h3F800000, 4'h1);
    run_op("tie_rup",      32'h3F800000, 32'h33800000, 1'b0, RUP, 32'h3F800001, 4'h1);
    run_op("tie_odd_rne",  32'h3F800001, 32'h33800000, 1'b0, RNE, 32'h3F800002, 4'h1);
    run_op("sticky_rup",   32'h3F800000, 32'h33000001, 1'b0, RUP, 32'h3F800001, 4'h1);
    run_op("neg_rdn",      32'hBF800000, 32'hB3800000, 1'b0, RDN, 32'hBF800001, 4'h1);
    run_op("inf_m_inf",    32'h7F800000, 32'h7F800000, 1'b1, RNE, 32'h7FC00000, 4'h8);
    run_op("subn_diff",    32'h00800000, 32'h00000001, 1'b1, RNE, 32'h007FFFFF, 4'h0);
    run_op("subn_sum",     32'h00400000, 32'h00400000, 1'b0, RNE, 32'h00800000, 4'h0);
    run_op("snan",         32'h7F800001, 32'h3F800000, 1'b0, RNE, 32'h7FC00000, 4'h8);
    run_op("qnan",         32'h3F800000, 32'hFFC00001, 1'b0, RNE, 32'h7FC00000, 4'h0);
    run_op("ninf_fin",     32'hFF800000, 32'h3F800000, 1'b0, RNE, 32'hFF800000, 4'h0);
    run_op("nzero_nzero",  32'h80000000, 32'h80000000, 1'b0, RNE, 32'h80000000, 4'h0);
    run_op("one_m_two",    32'h3F800000, 32'h40000000, 1'b1, RNE, 32'hBF800000, 4'h0);
    run_op("frac_add",     32'h3FC00000, 32'h3E800000, 1'b0, RTZ, 32'h3FE00000, 4'h0);

    // Back-pressure: result and flags must hold while Out_ready is low.
    Out_ready = 1'b0;
    run_op("hold", 32'h3FC00000, 32'h3E800000, 1'b0, RNE, 32'h3FE00000, 4'h0);
    bad = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (Dataout !== 32'h3FE00000 || Dataout_valid !== 1'b1 || In_ready !== 1'b0 ||
          Exc !== 4'h0) bad++;
    end
    check_eq("hold.stable", 32'(bad), 32'd0);
    check_eq("hold.debug", 32'(Debug), 32'd5);
    Out_ready = 1'b1;
    @(posedge CLK); #1;
    check_eq("hold.release", {29'd0, Dataout_valid, In_ready, |Exc}, 32'd2);

    // Reset while in ADD discards the operation.
    Datain1 = 32'h3F800000; Datain2 = 32'h3F800000; Sub = 1'b0; Rnd_mode = RNE;
    In_valid = 1'b1;
    @(posedge CLK); #1;
    In_valid = 1'b0;
    @(posedge CLK); #1;
    check_eq("mid.debug_add", 32'(Debug), 32'd2);
    RSTn = 1'b0;
    #2;
    check_eq("mid.in_reset", {25'd0, Dataout_valid, Debug, Exc}, 32'd0);
    check_eq("mid.data", Dataout, 32'd0);
    #1 RSTn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (Dataout_valid) seen++;
    end
    check_eq("mid.no_valid", 32'(seen), 32'd0);
    check_eq("mid.ready", 32'(In_ready), 32'd1);
    check_eq("mid.debug_idle", 32'(Debug), 32'd0);
    run_op("after_rst", 32'h40000000, 32'h3F800000, 1'b1, RNE, 32'h3F800000, 4'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
